// File: rtl/pwm_decoder_module.sv
// Measures high time and rising-edge-to-rising-edge period of an asynchronous pulse train.
// Results are published as a one-cycle Valid_out strobe; Timeout_out flags a stalled input.
module pwm_decoder_module #(
    parameter int unsigned        CNT_W   = 23,
    parameter logic [CNT_W-1:0]   TIMEOUT = CNT_W'(6_000_000)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PULSE_in,
    output logic [CNT_W-1:0] High_out,
    output logic [CNT_W-1:0] Period_out,
    output logic             Valid_out,
    output logic             Timeout_out,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;

    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_cap;
    logic [CNT_W-1:0] p_cap;
    logic             pend;
    logic             p_at_limit;
    logic             load_period;
    logic             set_timeout;

    assign rise       = s2 & ~s3;
    assign fall       = ~s2 & s3;
    assign p_at_limit = (p_cnt == TIMEOUT);
    assign state_dbg  = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A rise always wins over a coincident timeout.
    always_comb begin
        state_nxt   = state;
        load_period = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (rise) begin
                    state_nxt = HIGH;
                end else if (p_at_limit) begin
                    state_nxt   = IDLE;
                    set_timeout = 1'b1;
                end else if (fall) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt   = HIGH;
                    load_period = 1'b1;
                end else if (p_at_limit) begin
                    state_nxt   = IDLE;
                    set_timeout = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            p_cnt       <= '0;
            h_cnt       <= '0;
            h_cap       <= '0;
            p_cap       <= '0;
            pend        <= 1'b0;
            High_out    <= '0;
            Period_out  <= '0;
            Valid_out   <= 1'b0;
            Timeout_out <= 1'b0;
        end else begin
            s1 <= PULSE_in;
            s2 <= s1;
            s3 <= s2;

            if (rise) begin
                p_cnt <= CNT_W'(1);
                h_cnt <= CNT_W'(1);
            end else begin
                if (state != IDLE) begin
                    p_cnt <= p_cnt + CNT_W'(1);
                end
                if (state == HIGH) begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end

            if ((state == HIGH) && fall) begin
                h_cap <= h_cnt;
            end

            // The period count is restarted on the closing rise, so it is parked
            // in p_cap and published together with h_cap one cycle later.
            if (load_period) begin
                p_cap <= p_cnt;
            end
            pend      <= load_period;
            Valid_out <= pend;
            if (pend) begin
                Period_out <= p_cap;
                High_out   <= h_cap;
            end

            if (rise) begin
                Timeout_out <= 1'b0;
            end else if (set_timeout) begin
                Timeout_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder_module.sv
// Randomized bench for pwm_decoder_module: an event-level reference model predicts every
// output each cycle, with a few hand-computed literal checks for latency and timeout timing.
module tb_pwm_decoder_module;

    localparam int               CNT_W = 16;
    localparam int               TMO_I = 100;
    localparam logic [CNT_W-1:0] TMO   = 16'd100;

    logic             CLK = 1'b0;
    logic             RST;
    logic             PULSE_in;
    logic [CNT_W-1:0] High_out;
    logic [CNT_W-1:0] Period_out;
    logic             Valid_out;
    logic             Timeout_out;
    logic [1:0]       state_dbg;

    pwm_decoder_module #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PULSE_in    (PULSE_in),
        .High_out    (High_out),
        .Period_out  (Period_out),
        .Valid_out   (Valid_out),
        .Timeout_out (Timeout_out),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on sample timestamps: a rise/fall of the input is acted on two edges after it is
    // first sampled; a measurement is "alive" from one acted rise until the next rise or until
    // TIMEOUT edges pass without one.
    bit smp_q[$];
    bit model_on = 1'b0;
    bit m_rise;
    bit m_fall;
    bit alive;
    bit pend_v;
    int now_t;
    int r_t;
    int f_t;
    int pend_h;
    int pend_p;
    int exp_high;
    int exp_per;
    bit exp_valid;
    bit exp_to;

    always @(posedge CLK) begin
        if (RST) begin
            smp_q     = '{1'b0, 1'b0, 1'b0};
            alive     = 1'b0;
            pend_v    = 1'b0;
            now_t     = 0;
            r_t       = 0;
            f_t       = -1;
            exp_high  = 0;
            exp_per   = 0;
            exp_valid = 1'b0;
            exp_to    = 1'b0;
            model_on  = 1'b1;
        end else begin
            m_rise = smp_q[1] && !smp_q[2];
            m_fall = !smp_q[1] && smp_q[2];
            now_t++;
            exp_valid = 1'b0;
            if (pend_v) begin
                exp_valid = 1'b1;
                exp_high  = pend_h;
                exp_per   = pend_p;
                pend_v    = 1'b0;
            end
            if (m_rise) begin
                if (alive) begin
                    pend_v = 1'b1;
                    pend_p = now_t - r_t;
                    pend_h = f_t - r_t;
                end
                alive  = 1'b1;
                r_t    = now_t;
                f_t    = -1;
                exp_to = 1'b0;
            end else begin
                if (m_fall && alive && f_t < 0) f_t = now_t;
                if (alive && (now_t - r_t) == TMO_I) begin
                    alive  = 1'b0;
                    exp_to = 1'b1;
                end
            end
            smp_q.push_front(PULSE_in);
            void'(smp_q.pop_back());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (model_on) begin
            chk("valid",     32'(Valid_out),          32'(exp_valid));
            chk("timeout",   32'(Timeout_out),        32'(exp_to));
            chk("high",      32'(High_out),           32'(exp_high));
            chk("period",    32'(Period_out),         32'(exp_per));
            chk("measuring", 32'(state_dbg != 2'd0),  32'(alive));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge CLK);
            PULSE_in = v;
        end
    endtask

    task automatic pulse_period(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST      = 1'b1;
        PULSE_in = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Idle input never yields a strobe or a timeout.
        drive(1'b0, 2 * TMO_I);
        @(negedge CLK);
        chk("idle_valid",   32'(Valid_out),   32'd0);
        chk("idle_timeout", 32'(Timeout_out), 32'd0);
        chk("idle_high",    32'(High_out),    32'd0);
        chk("idle_period",  32'(Period_out),  32'd0);

        // 3 high / 7 low: strobe lands on the 4th edge after the first high sample.
        pulse_period(3, 7);
        @(negedge CLK); PULSE_in = 1'b1;
        @(negedge CLK); chk("lat_e0", 32'(Valid_out), 32'd0);
        @(negedge CLK); chk("lat_e1", 32'(Valid_out), 32'd0);
        @(negedge CLK); chk("lat_e2", 32'(Valid_out), 32'd0); PULSE_in = 1'b0;
        @(negedge CLK);
        chk("lat_e3",     32'(Valid_out),  32'd1);
        chk("lat_high",   32'(High_out),   32'd3);
        chk("lat_period", 32'(Period_out), 32'd10);
        drive(1'b0, 5);
        repeat (3) pulse_period(3, 7);
        chk("run_high",   32'(High_out),   32'd3);
        chk("run_period", 32'(Period_out), 32'd10);

        // Input goes quiet: timeout exactly 102 edges after the first high sample.
        @(negedge CLK); PULSE_in = 1'b1;
        for (int j = 1; j <= 103; j++) begin
            @(negedge CLK);
            if (j == 3)   PULSE_in = 1'b0;
            if (j == 102) chk("tmo_early", 32'(Timeout_out), 32'd0);
            if (j == 103) chk("tmo_set",   32'(Timeout_out), 32'd1);
        end
        pulse_period(3, 7);
        chk("tmo_clear", 32'(Timeout_out), 32'd0);
        pulse_period(3, 7);

        // Stuck high: abandon measurement, keep previous results.
        pulse_period(4, 9);
        pulse_period(4, 9);
        drive(1'b1, 120);
        chk("stuck_timeout", 32'(Timeout_out), 32'd1);
        chk("stuck_idle",    32'(state_dbg),   32'd0);
        chk("stuck_high",    32'(High_out),    32'd4);
        chk("stuck_period",  32'(Period_out),  32'd13);
        drive(1'b0, 10);

        // Reset in the middle of a high phase.
        pulse_period(3, 7);
        pulse_period(3, 7);
        drive(1'b1, 5);
        pulse_reset();
        chk("rst_valid",   32'(Valid_out),   32'd0);
        chk("rst_timeout", 32'(Timeout_out), 32'd0);
        chk("rst_high",    32'(High_out),    32'd0);
        chk("rst_period",  32'(Period_out),  32'd0);
        drive(1'b1, 2);
        drive(1'b0, 7);
        pulse_period(3, 7);
        pulse_period(3, 7);
        chk("rst_rec_high",   32'(High_out),   32'd3);
        chk("rst_rec_period", 32'(Period_out), 32'd10);

        // Randomized periods, occasional long gaps and resets.
        for (int k = 0; k < 60; k++) begin
            int h;
            int l;
            h = int'($urandom_range(1, 20));
            l = int'($urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) l = int'($urandom_range(90, 130));
            pulse_period(h, l);
            if ($urandom_range(0, 19) == 0) pulse_reset();
        end
        drive(1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
